// File: rtl/fwd_pipe_if.sv
// fwd_pipe_if: bundle of the decode-side bypass/interlock signals.
//   Parameters: W data width, NR read ports, NS tracked stages, RSW ready-stage width.
//   master: decode/pipeline side; drives read addresses, RF data, issue info,
//           flush/hold and per-stage results; receives operands, stall, stall_cnt.
//   slave:  fwd_pipe side (mirror of master).
interface fwd_pipe_if #(
    parameter int unsigned W   = 32,
    parameter int unsigned NR  = 2,
    parameter int unsigned NS  = 3,
    parameter int unsigned RSW = $clog2(NS + 1)
);
    logic [NR*5-1:0] ra;
    logic [NR-1:0]   ru;
    logic [NR*W-1:0] rd;
    logic            iss_we;
    logic [4:0]      iss_wa;
    logic [RSW-1:0]  iss_rs;
    logic            flush;
    logic            hold;
    logic [NS*W-1:0] st_wd;
    logic [NR*W-1:0] r;
    logic            stall;
    logic [31:0]     stall_cnt;

    modport master (
        output ra, ru, rd, iss_we, iss_wa, iss_rs, flush, hold, st_wd,
        input  r, stall, stall_cnt
    );

    modport slave (
        input  ra, ru, rd, iss_we, iss_wa, iss_rs, flush, hold, st_wd,
        output r, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_pipe.sv
// fwd_pipe: register bypass selection and load-use interlock for the decode stage.
// Tracks {valid, dest reg, ready stage} for NS downstream stages and, per read port,
// forwards the youngest in-flight result or raises stall when it is not produced yet.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; clears stage valids and the stall counter
//   bus    fwd_pipe_if.slave: ra/ru/rd read ports, iss_* issue info, flush, hold,
//          st_wd stage results; outputs r (operands), stall, stall_cnt
// Optional feature: define FWD_STALLCNT_EN to build the saturating stall-cycle counter;
// otherwise stall_cnt is tied to zero.
module fwd_pipe #(
    parameter int unsigned W   = 32,
    parameter int unsigned NR  = 2,
    parameter int unsigned NS  = 3,
    parameter int unsigned RSW = $clog2(NS + 1)
) (
    input logic      clk,
    input logic      reset,
    fwd_pipe_if.slave bus
);

    // Index s holds pipeline stage s+1.
    logic [NS-1:0]  v_q;
    logic [4:0]     wa_q [NS];
    logic [RSW-1:0] rs_q [NS];

    logic [NR-1:0]   hit;
    logic [NR-1:0]   rdy;
    logic [W-1:0]    val [NR];
    logic [NR-1:0]   hazard;
    logic [NR*W-1:0] r_c;
    logic            stall_c;
    logic [RSW-1:0]  rs_clamped;
    logic            issue_v;

    always_comb begin
        hazard = '0;
        r_c    = '0;
        for (int p = 0; p < NR; p++) begin
            hit[p] = 1'b0;
            rdy[p] = 1'b0;
            val[p] = bus.rd[p*W +: W];
            // Walk oldest to youngest so the youngest match is the one left standing.
            for (int s = NS - 1; s >= 0; s--) begin
                if (v_q[s] && (wa_q[s] == bus.ra[p*5 +: 5])) begin
                    hit[p] = 1'b1;
                    rdy[p] = (RSW'(s + 1) >= rs_q[s]);
                    val[p] = bus.st_wd[s*W +: W];
                end
            end
            // r0 is hardwired zero and never forwarded.
            if (bus.ra[p*5 +: 5] == 5'd0) begin
                hit[p] = 1'b0;
                val[p] = '0;
            end
            hazard[p]      = bus.ru[p] && hit[p] && !rdy[p];
            r_c[p*W +: W]  = val[p];
        end
        stall_c = |hazard;
    end

    // Clamping keeps every entry ready by the last stage, so a stall always resolves.
    always_comb begin
        rs_clamped = bus.iss_rs;
        if (bus.iss_rs == '0) begin
            rs_clamped = RSW'(1);
        end else if (32'(bus.iss_rs) > NS) begin
            rs_clamped = RSW'(NS);
        end
    end

    // A stalled or flushed instruction becomes a bubble; writes to r0 are never tracked.
    assign issue_v = bus.iss_we && (bus.iss_wa != 5'd0) && !stall_c && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else if (!bus.hold) begin
            for (int s = NS - 1; s >= 1; s--) begin
                v_q[s] <= v_q[s-1];
            end
            v_q[0] <= issue_v;
        end
    end

    // Address/ready fields are only meaningful when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!bus.hold) begin
            for (int s = NS - 1; s >= 1; s--) begin
                wa_q[s] <= wa_q[s-1];
                rs_q[s] <= rs_q[s-1];
            end
            wa_q[0] <= bus.iss_wa;
            rs_q[0] <= rs_clamped;
        end
    end

    assign bus.r     = r_c;
    assign bus.stall = stall_c;

`ifdef FWD_STALLCNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall_c && !bus.hold && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_pipe.sv
// tb_fwd_pipe: self-checking bench for fwd_pipe (W=32, NR=2, NS=3).
// Each cycle's expected outputs are queued when inputs are driven and popped and
// compared at the falling edge; a vector table covers single-cycle behaviour and
// hand-written sequences cover hold, stall counting and mid-flight reset.
module tb_fwd_pipe;
    localparam int unsigned W   = 32;
    localparam int unsigned NR  = 2;
    localparam int unsigned NS  = 3;
    localparam int unsigned RSW = 2;

    localparam logic [31:0] D0 = 32'hD0D0_0000;
    localparam logic [31:0] D1 = 32'hD1D1_0000;
    localparam logic [31:0] S1 = 32'h5100_0001;
    localparam logic [31:0] S2 = 32'h5200_0002;
    localparam logic [31:0] S3 = 32'h5300_0003;

`ifdef FWD_STALLCNT_EN
    localparam logic [31:0] HOLD_CNT = 32'd2;
`else
    localparam logic [31:0] HOLD_CNT = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fwd_pipe_if #(.W(W), .NR(NR), .NS(NS), .RSW(RSW)) bus ();

    fwd_pipe #(.W(W), .NR(NR), .NS(NS), .RSW(RSW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  ru;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  rs;
        logic        flush;
        logic [31:0] er0;
        logic [31:0] er1;
        logic        es;
        logic        c0;
        logic        c1;
    } vec_t;

    typedef struct packed {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] cnt;
        logic        stall;
        logic        c0;
        logic        c1;
        logic        cc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];
    int    errors = 0;
    int    checks = 0;

    function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] ru, input logic we, input logic [4:0] wa,
                                input logic [1:0] rs, input logic flush,
                                input logic [31:0] er0, input logic [31:0] er1,
                                input logic es, input logic c0, input logic c1);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.ru = ru;
        v.rd0 = D0;  v.rd1 = D1;
        v.s1 = S1;   v.s2 = S2;   v.s3 = S3;
        v.we = we;   v.wa = wa;   v.rs = rs; v.flush = flush;
        v.er0 = er0; v.er1 = er1; v.es = es; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic hold);
        bus.ra     = {v.ra1, v.ra0};
        bus.ru     = v.ru;
        bus.rd     = {v.rd1, v.rd0};
        bus.st_wd  = {v.s3, v.s2, v.s1};
        bus.iss_we = v.we;
        bus.iss_wa = v.wa;
        bus.iss_rs = v.rs;
        bus.flush  = v.flush;
        bus.hold   = hold;
    endtask

    task automatic push_exp(input string n, input logic [31:0] r0, input logic [31:0] r1,
                            input logic stall, input logic c0, input logic c1,
                            input logic cc, input logic [31:0] cnt);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.cnt = cnt; e.stall = stall;
        e.c0 = c0; e.c1 = c1; e.cc = cc;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic compare_all();
        exp_t  e;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (bus.stall !== e.stall) begin
                errors++;
                $display("FAIL %s stall: got %0b want %0b", n, bus.stall, e.stall);
            end
            if (e.c0) begin
                checks++;
                if (bus.r[31:0] !== e.r0) begin
                    errors++;
                    $display("FAIL %s r0: got %h want %h", n, bus.r[31:0], e.r0);
                end
            end
            if (e.c1) begin
                checks++;
                if (bus.r[63:32] !== e.r1) begin
                    errors++;
                    $display("FAIL %s r1: got %h want %h", n, bus.r[63:32], e.r1);
                end
            end
            if (e.cc) begin
                checks++;
                if (bus.stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", n, bus.stall_cnt, e.cnt);
                end
            end
        end
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic sample_and_step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic with_hold);
        vec_t idle;
        idle = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle, with_hold);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.hold = 1'b0;
    endtask

    initial begin
        vec_t v;

        // r0 with rd0 = 1111, then ra0 = 0 forces zero
        v = mk(5, 0, 2'b01, 0, 0, 0, 0, 32'h1111, 0, 0, 1, 1); v.rd0 = 32'h1111; tbl.push_back(v);
        v = mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 1); v.rd0 = 32'hFFFF; tbl.push_back(v);
        // wa=5 rs=1 walks through stages 1..3 and retires
        tbl.push_back(mk(0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 1, 1));
        v = mk(5, 0, 2'b01, 0, 0, 0, 0, 32'hA5, 0, 0, 1, 1); v.s1 = 32'hA5; tbl.push_back(v);
        tbl.push_back(mk(5, 0, 2'b01, 0, 0, 0, 0, S2, 0, 0, 1, 1));
        v = mk(5, 0, 2'b01, 0, 0, 0, 0, 32'hA5, 0, 0, 1, 1); v.s3 = 32'hA5; tbl.push_back(v);
        tbl.push_back(mk(5, 0, 2'b01, 0, 0, 0, 0, D0, 0, 0, 1, 1));
        // load-use: wa=7 rs=2, one stall cycle; the wa=8 issue during stall is dropped
        tbl.push_back(mk(0, 0, 2'b00, 1, 7, 2, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 7, 2'b10, 1, 8, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(8, 7, 2'b11, 0, 0, 0, 0, D0, S2, 0, 1, 1));
        tbl.push_back(mk(0, 7, 2'b10, 0, 0, 0, 0, 0, S3, 0, 1, 1));
        // same with ru1=0: never stalls, operand still forwarded
        tbl.push_back(mk(0, 0, 2'b00, 1, 7, 2, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 7, 2'b00, 0, 0, 0, 0, 0, S1, 0, 1, 1));
        tbl.push_back(mk(0, 7, 2'b00, 0, 0, 0, 0, 0, S2, 0, 1, 1));
        // back-to-back writes to r9: youngest wins
        tbl.push_back(mk(0, 0, 2'b00, 1, 9, 1, 0, 0, 0, 0, 1, 1));
        v = mk(9, 0, 2'b01, 1, 9, 1, 0, 32'h1, 0, 0, 1, 1); v.s1 = 32'h1; tbl.push_back(v);
        v = mk(9, 9, 2'b11, 0, 0, 0, 0, 32'h2, 32'h2, 0, 1, 1);
        v.s1 = 32'h2; v.s2 = 32'h1; tbl.push_back(v);
        v = mk(9, 0, 2'b01, 0, 0, 0, 0, 32'h2, 0, 0, 1, 1);
        v.s2 = 32'h2; v.s3 = 32'h1; tbl.push_back(v);
        // flushed issue never enters the pipe
        tbl.push_back(mk(0, 0, 2'b00, 1, 4, 1, 1, 0, 0, 0, 1, 1));
        v = mk(4, 0, 2'b01, 0, 0, 0, 0, 32'h4444, 0, 0, 1, 1); v.rd0 = 32'h4444; tbl.push_back(v);
        // rs=0 clamps to 1: ready in stage 1
        tbl.push_back(mk(0, 0, 2'b00, 1, 10, 0, 0, 0, 0, 0, 1, 1));
        v = mk(10, 0, 2'b01, 0, 0, 0, 0, 32'hABCD, 0, 0, 1, 1); v.s1 = 32'hABCD; tbl.push_back(v);

        reset = 1'b1;
        drive(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        push_exp("reset_state", D0, 0, 0, 1, 1, 1, 0);
        drive(mk(5, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        sample_and_step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i], 1'b0);
            push_exp($sformatf("row%0d", i), tbl[i].er0, tbl[i].er1, tbl[i].es,
                     tbl[i].c0, tbl[i].c1, 1'b0, 0);
            sample_and_step();
        end

        // hold with wa=3 rs=3 in stage 1: stall persists, stage contents frozen
        do_reset(1'b0);
        push_exp("hold_post_reset", 0, 0, 0, 1, 0, 1, 0);
        drive(mk(0, 0, 2'b00, 1, 3, 3, 0, 0, 0, 0, 0, 0), 1'b0);
        sample_and_step();
        for (int i = 0; i < 4; i++) begin
            drive(mk(3, 3, 2'b01, 1, 11, 1, 0, 0, 0, 0, 0, 0), 1'b1);
            push_exp($sformatf("hold%0d", i), 0, S1, 1, 0, 1, 0, 0);
            sample_and_step();
        end
        drive(mk(3, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        push_exp("release_s1", 0, S1, 1, 0, 1, 0, 0);
        sample_and_step();
        push_exp("release_s2", 0, S2, 1, 0, 1, 0, 0);
        sample_and_step();
        push_exp("release_s3", S3, S3, 0, 1, 1, 1, HOLD_CNT);
        sample_and_step();

        // reset (together with hold) discards an entry sitting in stage 2
        drive(mk(0, 0, 2'b00, 1, 6, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        sample_and_step();
        drive(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        sample_and_step();
        drive(mk(6, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        push_exp("pre_reset_s2", S2, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        compare_all();
        do_reset(1'b1);
        drive(mk(6, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        push_exp("post_reset_rd", D0, 0, 0, 1, 0, 1, 0);
        sample_and_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_pipe.md
# fwd_pipe

Parametrised register-bypass and load-use interlock unit for the pipeline's decode stage. It keeps its own shadow pipeline of in-flight destination registers across NS downstream stages and selects, for each of NR operand read ports, the youngest in-flight result. When that result is not yet produced, it raises a stall. It replaces hand-instantiated per-port forwarding muxes and separate hazard logic with one block that owns both the bypass selection and the destination tracking.

## Interface
- `W`, 32, data width.
- `NR`, 2, number of operand read ports.
- `NS`, 3, number of tracked stages after decode (stage 1 = E … stage NS = last stage before register-file write completes).
- `RSW`, `$clog2(NS+1)`, width of the ready-stage field.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all stage valid bits and the stall counter.
- `ra`  in  NR*5  read-register addresses; port p = bits [5p+4:5p].
- `ru`  in  NR  port p operand is actually used by the decoding instruction.
- `rd`  in  NR*W  register-file read data per port.
- `iss_we`  in  1  decoding instruction writes a register.
- `iss_wa`  in  5  its destination register.
- `iss_rs`  in  RSW  first stage (1..NS) at which its result is valid on `st_wd`.
- `flush`  in  1  kill the decoding instruction (bubble enters stage 1).
- `hold`  in  1  freeze the whole downstream pipeline this cycle.
- `st_wd`  in  NS*W  result value currently held in stage s (s = 1..NS, slice s-1).
- `r`  out  NR*W  forwarded operands.
- `stall`  out  1  decode must not advance.
- `stall_cnt`  out  32  stall-cycle counter (see Configuration).

## Operation
- Stage entry: {v, wa, rs}. An entry matches port p iff v && wa == ra[p] && ra[p] != 0. An entry is ready in stage s iff s >= rs.
- `iss_rs` is clamped at issue: 0 → 1, >NS → NS. This guarantees that stage NS is always ready and that no deadlock can occur.
- Per port p:
  - ra[p] == 0 → r[p] = 0.
  - Otherwise the smallest matching s (youngest) wins, with r[p] = st_wd[s]. Older matches are ignored.
  - No match → r[p] = rd[p].
- Per-port hazard: ru[p] && the youngest match exists && that match is not ready. `stall` = OR of all port hazards.
  - `r[p]` for a hazarded port is don't-care.
  - A port with ru[p] = 0 never stalls.
- Advance when !hold:
  - stage s ← stage s-1 for s = 2..NS.
  - The stage-NS entry retires.
  - stage 1 ← {iss_we && iss_wa != 0 && !stall && !flush, iss_wa, clamp(iss_rs)}.
- When hold = 1, no stage changes. `stall` and `r` are still evaluated combinationally.
- Simultaneous events:
  - flush with stall → bubble (the same outcome either way).
  - hold takes priority over everything except reset.
  - reset takes priority over hold.

## Timing
- `r` and `stall` are purely combinational from ra/ru/rd/st_wd and the stage registers. There are no extra cycles.
- Stage registers advance on the rising edge. An instruction issued in cycle t is visible in stage 1 in cycle t+1 and in stage k in cycle t+k (absent hold).
- Load-use case (rs = 2, dependent instruction immediately behind): 1 stall cycle, then the value is forwarded from stage 2.
- After reset: all v = 0, stall = 0, r[p] = (ra[p] ? rd[p] : 0), stall_cnt = 0.
- Reset mid-operation discards every in-flight entry on the same edge.

## Configuration
- `FWD_STALLCNT_EN` defined:
  - `stall_cnt` increments by 1 on every edge where stall && !hold && !reset.
  - It saturates at 32'hFFFFFFFF.
  - It clears on reset.
- Not defined: `stall_cnt` is tied to 0 and no counter flops are generated.

## Test plan
- Parameters: W=32, NR=2, NS=3.
- Reset, then ra0=5, rd0=32'h1111, ru0=1 → r0=32'h1111, stall=0. Then ra0=0 with rd0=32'hFFFF → r0=0.
- Issue we, wa=5, rs=1, then next cycle st_wd[1]=32'hA5 with ra0=5 → r0=32'hA5, stall=0. Two cycles later the entry is in stage 3 with st_wd[3]=32'hA5 → r0=32'hA5. One cycle after that the entry has retired → r0=rd0.
- Issue wa=7, rs=2, then immediately ra1=7, ru1=1 → stall=1 for exactly 1 cycle (bubble enters stage 1). Next cycle r1=st_wd[2], stall=0.
- Same as previous but ru1=0 → stall=0 throughout.
- Back-to-back writes to r9: first rs=1 value 32'h1, second rs=1 value 32'h2, then read r9 → r=32'h2 (youngest, stage 1), never 32'h1.
- Issue wa=3, rs=3, then ra0=3 with hold=1 for 4 cycles → stall stays 1 and the stage contents stay unchanged. Release hold → 2 stall cycles, then the value is forwarded from stage 3.
- Same scenario with `FWD_STALLCNT_EN` → stall_cnt = 2.
- Issue wa=4 with flush=1, then read r4 → no match, r=rd, stall=0.
- Assert reset while stage 2 holds wa=6 → next cycle read r6 returns rd.
